// File: rtl/sr_crypto_seq_pkg.sv
// Shared definitions for the scalar-crypto sequencer: state encodings and
// register-file write-port select values.
package sr_crypto_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'b00,
        SEQ_ISSUE = 2'b01,
        SEQ_WAIT  = 2'b10,
        SEQ_WB    = 2'b11
    } seq_state_t;

    // RF write-port mux select: normal control path vs. crypto sequencer.
    localparam logic SELECT_COMB = 1'b0;
    localparam logic SELECT_CRYP = 1'b1;

    // Watchdog counter width able to hold 0..timeout.
    function automatic int wdog_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sr_crypto_wdog.sv
// Watchdog for the crypto sequencer: counts enabled cycles since the last
// clear and flags the cycle in which the count reaches TIMEOUT-1.
module sr_crypto_wdog
    import sr_crypto_seq_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = wdog_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire = en && (cnt == LAST);

endmodule

// File: rtl/sr_crypto_seq.sv
// Multi-cycle sequencer between decode and the scalar-crypto unit: stalls the
// PC, issues a valid/ready request, waits for the result and writes it back.
module sr_crypto_seq
    import sr_crypto_seq_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MODE_W  = 21,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cry_instr,
    input  logic [MODE_W-1:0] cry_mode,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [4:0]        rd_addr,
    output logic              hold,
    output logic              ctrls_select,
    output logic              wb_we,
    output logic [4:0]        wb_addr,
    output logic [XLEN-1:0]   wb_data,
    output logic              u_valid,
    input  logic              u_ready,
    output logic [MODE_W-1:0] u_mode,
    output logic [XLEN-1:0]   u_op1,
    output logic [XLEN-1:0]   u_op2,
    input  logic              u_done,
    input  logic [XLEN-1:0]   u_result,
    output logic              err_timeout
);

    seq_state_t state, state_n;
    logic       expire;
    logic       abort;
    logic       start;
    logic       busy;

    assign start = (state == SEQ_IDLE) && cry_instr;
    assign busy  = (state == SEQ_ISSUE) || (state == SEQ_WAIT);

    sr_crypto_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start),
        .en     (busy),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_n      = state;
        hold         = 1'b0;
        ctrls_select = SELECT_COMB;
        abort        = 1'b0;
        case (state)
            SEQ_IDLE: begin
                if (cry_instr) begin
                    hold    = 1'b1;
                    state_n = SEQ_ISSUE;
                end
            end
            SEQ_ISSUE: begin
                hold         = 1'b1;
                ctrls_select = SELECT_CRYP;
                if (u_ready) begin
                    state_n = SEQ_WAIT;
                end else if (expire) begin
                    abort   = 1'b1;
                    state_n = SEQ_WB;
                end
            end
            SEQ_WAIT: begin
                hold         = 1'b1;
                ctrls_select = SELECT_CRYP;
                if (u_done) begin
                    state_n = SEQ_WB;
                end else if (expire) begin
                    abort   = 1'b1;
                    state_n = SEQ_WB;
                end
            end
            SEQ_WB: begin
                ctrls_select = SELECT_CRYP;
                state_n      = SEQ_IDLE;
            end
            default: state_n = SEQ_IDLE;
        endcase
    end

    // Operand/result latches; err_timeout is registered so it lands in the
    // write-back cycle of the aborted operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_mode      <= '0;
            u_op1       <= '0;
            u_op2       <= '0;
            wb_addr     <= '0;
            wb_data     <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (start) begin
                u_mode  <= cry_mode;
                u_op1   <= rs1_val;
                u_op2   <= rs2_val;
                wb_addr <= rd_addr;
            end
            if ((state == SEQ_WAIT) && u_done) begin
                wb_data <= u_result;
            end else if (abort) begin
                wb_data <= '0;
            end
            err_timeout <= abort;
        end
    end

    assign u_valid = (state == SEQ_ISSUE);
    assign wb_we   = (state == SEQ_WB) && (wb_addr != 5'd0);

endmodule

// File: tb/tb_sr_crypto_seq.sv
// Self-checking bench for sr_crypto_seq: directed scenarios with literal
// expectations plus randomized traffic compared against a transaction model.
module tb_sr_crypto_seq;

    localparam int XLEN    = 32;
    localparam int MODE_W  = 21;
    localparam int TIMEOUT = 8;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              cry_instr = 1'b0;
    logic [MODE_W-1:0] cry_mode  = '0;
    logic [XLEN-1:0]   rs1_val   = '0;
    logic [XLEN-1:0]   rs2_val   = '0;
    logic [4:0]        rd_addr   = '0;
    logic              u_ready   = 1'b0;
    logic              u_done    = 1'b0;
    logic [XLEN-1:0]   u_result  = '0;

    logic              hold;
    logic              ctrls_select;
    logic              wb_we;
    logic [4:0]        wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              u_valid;
    logic [MODE_W-1:0] u_mode;
    logic [XLEN-1:0]   u_op1;
    logic [XLEN-1:0]   u_op2;
    logic              err_timeout;

    sr_crypto_seq #(.XLEN(XLEN), .MODE_W(MODE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cry_instr    (cry_instr),
        .cry_mode     (cry_mode),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .rd_addr      (rd_addr),
        .hold         (hold),
        .ctrls_select (ctrls_select),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .u_valid      (u_valid),
        .u_ready      (u_ready),
        .u_mode       (u_mode),
        .u_op1        (u_op1),
        .u_op2        (u_op2),
        .u_done       (u_done),
        .u_result     (u_result),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction model: an operation is in flight (busy), has been granted by
    // the unit or not, and is followed by exactly one write-back cycle.
    bit              m_busy    = 1'b0;
    bit              m_granted = 1'b0;
    bit              m_wb      = 1'b0;
    bit              m_err     = 1'b0;
    int              m_age     = 0;
    logic [4:0]      m_rd      = '0;
    logic [XLEN-1:0] m_res     = '0;
    logic [XLEN-1:0] m_op1     = '0;
    logic [XLEN-1:0] m_op2     = '0;
    logic [MODE_W-1:0] m_mode  = '0;
    int unsigned     pc        = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_granted = 1'b0; m_wb = 1'b0; m_err = 1'b0; m_age = 0;
            m_rd = '0; m_res = '0; m_op1 = '0; m_op2 = '0; m_mode = '0;
        end else if (m_wb) begin
            m_wb  = 1'b0;
            m_err = 1'b0;
        end else if (!m_busy) begin
            if (cry_instr) begin
                m_busy = 1'b1; m_granted = 1'b0; m_age = 0;
                m_rd = rd_addr; m_op1 = rs1_val; m_op2 = rs2_val; m_mode = cry_mode;
            end
        end else begin
            if (!m_granted && u_ready) begin
                m_granted = 1'b1;
            end else if (m_granted && u_done) begin
                m_res = u_result; m_busy = 1'b0; m_wb = 1'b1;
            end else if (m_age == TIMEOUT - 1) begin
                m_res = '0; m_err = 1'b1; m_busy = 1'b0; m_wb = 1'b1;
            end
            m_age++;
        end
    end

    always @(posedge clk) begin
        if (rst_n && !hold) pc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_hold",   64'(hold),         64'(m_busy || (!m_wb && cry_instr)));
            check("m_select", 64'(ctrls_select), 64'(m_busy || m_wb));
            check("m_valid",  64'(u_valid),      64'(m_busy && !m_granted));
            check("m_wb_we",  64'(wb_we),        64'(m_wb && (m_rd != 5'd0)));
            check("m_wb_addr", 64'(wb_addr),     64'(m_rd));
            check("m_wb_data", 64'(wb_data),     64'(m_res));
            check("m_op1",    64'(u_op1),        64'(m_op1));
            check("m_op2",    64'(u_op2),        64'(m_op2));
            check("m_mode",   64'(u_mode),       64'(m_mode));
            check("m_err",    64'(err_timeout),  64'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [4:0] rd, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, input logic [MODE_W-1:0] mode);
        cry_instr = 1'b1; rd_addr = rd; rs1_val = a; rs2_val = b; cry_mode = mode;
    endtask

    int          err_cnt;
    int          err_idx;
    int unsigned pc0;

    initial begin
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_hold",    64'(hold),         64'(0));
        check("rst_select",  64'(ctrls_select), 64'(0));
        check("rst_valid",   64'(u_valid),      64'(0));
        check("rst_wb_we",   64'(wb_we),        64'(0));
        check("rst_err",     64'(err_timeout),  64'(0));
        check("rst_wb_addr", 64'(wb_addr),      64'(0));
        check("rst_wb_data", 64'(wb_data),      64'(0));
        check("rst_op1",     64'(u_op1),        64'(0));
        rst_n = 1'b1;
        step();

        // Basic op: minimum latency, PC advances exactly once.
        pc0 = pc;
        start_op(5'd5, 32'h12345678, 32'h9ABCDEF0, 21'h1A5A5);
        u_ready = 1'b1;
        @(negedge clk) check("basic_detect_hold", 64'(hold), 64'(1));
        step(); cry_instr = 1'b0;
        @(negedge clk) check("basic_issue_valid", 64'(u_valid), 64'(1));
        check("basic_issue_op2", 64'(u_op2), 64'h9ABCDEF0);
        step(); u_done = 1'b1; u_result = 32'hDEADBEEF;
        @(negedge clk) check("basic_wait_hold", 64'(hold), 64'(1));
        step(); u_done = 1'b0; u_result = '0;
        @(negedge clk);
        check("basic_wb_hold", 64'(hold),    64'(0));
        check("basic_wb_we",   64'(wb_we),   64'(1));
        check("basic_wb_addr", 64'(wb_addr), 64'(5));
        check("basic_wb_data", 64'(wb_data), 64'hDEADBEEF);
        step();
        @(negedge clk);
        check("basic_pc_adv",  64'(pc - pc0),    64'(1));
        check("basic_idle_sel", 64'(ctrls_select), 64'(0));

        // Backpressure: ready low for five ISSUE cycles, operands stable.
        start_op(5'd17, 32'hA5A5A5A5, 32'h5A5A5A5A, 21'h0F0F0);
        u_ready = 1'b0;
        @(negedge clk);
        step(); cry_instr = 1'b0; rs1_val = 32'h0; rs2_val = 32'h0; cry_mode = '0;
        for (int i = 0; i < 6; i++) begin
            u_ready = (i == 5);
            @(negedge clk);
            check("bp_valid", 64'(u_valid), 64'(1));
            check("bp_hold",  64'(hold),    64'(1));
            check("bp_op1",   64'(u_op1),   64'hA5A5A5A5);
            check("bp_mode",  64'(u_mode),  64'h0F0F0);
            step();
        end
        u_ready = 1'b0; u_done = 1'b1; u_result = 32'h0BADF00D;
        @(negedge clk) check("bp_wait_valid", 64'(u_valid), 64'(0));
        step(); u_done = 1'b0;
        @(negedge clk) check("bp_wb_data", 64'(wb_data), 64'h0BADF00D);
        step();

        // Destination x0: write-back cycle visited without a write.
        start_op(5'd0, 32'h1, 32'h2, 21'h3);
        u_ready = 1'b1;
        @(negedge clk);
        step(); cry_instr = 1'b0;
        @(negedge clk);
        step(); u_done = 1'b1; u_result = 32'h00012345;
        @(negedge clk);
        step(); u_done = 1'b0;
        @(negedge clk);
        check("x0_wb_we",  64'(wb_we),        64'(0));
        check("x0_select", 64'(ctrls_select), 64'(1));
        step();

        // Timeout: accepted but never completed.
        start_op(5'd9, 32'h77, 32'h88, 21'h99);
        @(negedge clk);
        step(); cry_instr = 1'b0;
        err_cnt = 0; err_idx = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (err_timeout) begin
                err_cnt++; err_idx = i;
                check("to_wb_we",   64'(wb_we),   64'(1));
                check("to_wb_data", 64'(wb_data), 64'(0));
                check("to_wb_addr", 64'(wb_addr), 64'(9));
            end
            step();
        end
        check("to_err_count", 64'(err_cnt), 64'(1));
        check("to_err_cycle", 64'(err_idx), 64'(8));

        // Timeout tie: completion in the expiry cycle wins.
        start_op(5'd12, 32'h5, 32'h6, 21'h7);
        @(negedge clk);
        step(); cry_instr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            u_done   = (i == 7);
            u_result = (i == 7) ? 32'hC0FFEE11 : 32'h11111111;
            @(negedge clk);
            if (i == 8) begin
                check("tie_err",     64'(err_timeout), 64'(0));
                check("tie_wb_we",   64'(wb_we),       64'(1));
                check("tie_wb_data", 64'(wb_data),     64'hC0FFEE11);
            end
            step();
        end
        u_done = 1'b0; u_ready = 1'b0;

        // Reset during WAIT: outputs clear immediately, then a clean op.
        start_op(5'd3, 32'hFEEDFACE, 32'hCAFEF00D, 21'h12);
        u_ready = 1'b1;
        @(negedge clk);
        step(); cry_instr = 1'b0;
        @(negedge clk);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("rr_valid",   64'(u_valid),      64'(0));
        check("rr_select",  64'(ctrls_select), 64'(0));
        check("rr_hold",    64'(hold),         64'(0));
        check("rr_wb_we",   64'(wb_we),        64'(0));
        check("rr_op1",     64'(u_op1),        64'(0));
        check("rr_wb_addr", 64'(wb_addr),      64'(0));
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        start_op(5'd22, 32'h1111, 32'h2222, 21'h33);
        @(negedge clk);
        step(); cry_instr = 1'b0;
        @(negedge clk);
        step(); u_done = 1'b1; u_result = 32'h600DCAFE;
        @(negedge clk);
        step(); u_done = 1'b0;
        @(negedge clk);
        check("rr_new_wb_we",   64'(wb_we),   64'(1));
        check("rr_new_wb_addr", 64'(wb_addr), 64'(22));
        check("rr_new_wb_data", 64'(wb_data), 64'h600DCAFE);
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cry_instr = ($urandom_range(0, 2) == 0);
            cry_mode  = MODE_W'($urandom);
            rs1_val   = $urandom;
            rs2_val   = $urandom;
            rd_addr   = 5'($urandom_range(0, 31));
            u_ready   = 1'($urandom_range(0, 1));
            u_done    = ($urandom_range(0, 3) == 0);
            u_result  = $urandom;
            step();
        end
        cry_instr = 1'b0; u_ready = 1'b0; u_done = 1'b0;
        repeat (TIMEOUT + 4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
